mskstate_shares_serializer: RTL and testbench

MSKSTATE_SHARES_SERIALIZER -- requirements
Module: mskstate_shares_serializer

---
 rtl/mskstate_shares_serializer.sv | 67 ++++++
 tb/tb_mskstate_shares_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mskstate_shares_serializer.sv
// mskstate_shares_serializer: reorders a bit-interleaved masked state into share-major
// order and streams it out as BUS_W-bit words with valid/ready handshaking.
// Optional macro MSKSER_ZEROIZE_EN wipes each buffer word once it has been accepted.
module mskstate_shares_serializer #(
    parameter int Nbits = 128,
    parameter int d     = 2,
    parameter int BUS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [d*Nbits-1:0] state_in,
    input  logic               state_valid,
    output logic               state_ready,
    output logic [BUS_W-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last
);
    localparam int W  = d * Nbits / BUS_W;
    localparam int CW = W > 1 ? $clog2(W) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [W-1:0][BUS_W-1:0] words;
    logic [d*Nbits-1:0]      reordered;
    logic                    last;

    // Share i occupies bits [i*Nbits +: Nbits]; its bit b sits at the MSB end of group b.
    for (genvar i = 0; i < d; i++) begin : g_share
        for (genvar b = 0; b < Nbits; b++) begin : g_bit
            assign reordered[i*Nbits+b] = state_in[b*d+d-i-1];
        end
    end

    assign last        = cnt == CW'(W - 1);
    assign state_ready = state == IDLE;
    assign dout_valid  = state == SEND;
    assign dout_last   = dout_valid && last;
`ifdef MSKSER_ZEROIZE_EN
    assign dout        = dout_valid ? words[cnt] : '0;
`else
    assign dout        = words[cnt];
`endif

    // Load on handshake, then step through the words one accept at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            words <= '0;
        end else if (state == IDLE) begin
            if (state_valid) begin
                words <= reordered;
                cnt   <= '0;
                state <= SEND;
            end
        end else if (dout_ready) begin
`ifdef MSKSER_ZEROIZE_EN
            words[cnt] <= '0;
`endif
            cnt   <= last ? '0 : cnt + CW'(1);
            state <= last ? IDLE : SEND;
        end
    end
endmodule

// File: tb/tb_mskstate_shares_serializer.sv
// tb_mskstate_shares_serializer: directed bench with a share-level reference model.
module tb_mskstate_shares_serializer;
    logic         clk = 0;
    logic         rst = 1;
    logic [255:0] state_in = '0;
    logic         state_valid = 0;
    logic         state_ready;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 0;
    logic         dout_last;

    int n_chk = 0;
    int n_fail = 0;

    mskstate_shares_serializer #(.Nbits(128), .d(2), .BUS_W(32)) dut (
        .clk(clk), .rst(rst), .state_in(state_in), .state_valid(state_valid),
        .state_ready(state_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    // Word k belongs to share k/4; its bit j is share bit b=(k%4)*32+j = state bit 2b+1-share.
    function automatic logic [7:0][31:0] expand(input logic [255:0] s);
        logic [7:0][31:0] r;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 32; j++)
                r[k][j] = s[2*((k%4)*32+j) + 1 - k/4];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: either idle or sending word m_idx of m_exp.
    logic             m_send = 0;
    int               m_idx = 0;
    logic [7:0][31:0] m_exp = '0;
    logic [31:0]      lw[$];
    logic             ll[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_send = 0;
            m_idx = 0;
        end else if (!m_send) begin
            if (state_valid) begin
                m_exp = expand(state_in);
                m_send = 1;
                m_idx = 0;
            end
        end else if (dout_ready) begin
            lw.push_back(dout);
            ll.push_back(dout_last);
            if (m_idx == 7) m_send = 0;
            else m_idx++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_dout_valid", 32'(dout_valid), 0);
            chk("rst_dout", dout, 0);
        end else begin
            chk("state_ready", 32'(state_ready), 32'(!m_send));
            chk("dout_valid", 32'(dout_valid), 32'(m_send));
            chk("dout_last", 32'(dout_last), 32'(m_send && m_idx == 7));
            if (m_send) chk("dout", dout, m_exp[m_idx]);
`ifdef MSKSER_ZEROIZE_EN
            else chk("dout_idle_zero", dout, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 200 && lw.size() < n; i++) tick();
        chk("log_count", lw.size(), n);
    endtask

    task automatic clear_log();
        lw.delete();
        ll.delete();
    endtask

    logic [31:0]  held_d;
    logic         held_l;
    logic [255:0] pat_a, pat_b, pat_c, pat_d;
    logic [7:0][31:0] e;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        pat_a = {128{2'b10}};
        pat_d = {128{2'b01}};
        for (int b = 0; b < 128; b++) begin
            pat_b[2*b+1] = b[0];
            pat_b[2*b]   = 1'b0;
        end
        pat_c = {32'h0123_4567, 32'h89ab_cdef, 32'hdead_beef, 32'h1357_9bdf,
                 32'h2468_ace0, 32'hfedc_ba98, 32'h7654_3210, 32'hc0ff_ee11};
        // Model pins: hand-derived words.
        e = expand(pat_a);
        chk("model_a_w0", e[0], 32'hffff_ffff);
        chk("model_a_w4", e[4], 32'h0000_0000);
        e = expand(pat_b);
        chk("model_b_w0", e[0], 32'haaaa_aaaa);
        e = expand(pat_d);
        chk("model_d_w7", e[7], 32'hffff_ffff);

        repeat (3) tick();
        rst = 0;
        #1;
        chk("reset_ready", 32'(state_ready), 1);
        chk("reset_valid", 32'(dout_valid), 0);
        chk("reset_last", 32'(dout_last), 0);
        chk("reset_dout", dout, 0);

        // Odd bits set: share 0 all ones, share 1 all zeros.
        clear_log();
        state_in = pat_a; state_valid = 1; dout_ready = 1;
        tick();
        state_valid = 0;
        wait_log(8);
        chk("a_w0", lw[0], 32'hffff_ffff);
        chk("a_w3", lw[3], 32'hffff_ffff);
        chk("a_w4", lw[4], 32'h0000_0000);
        chk("a_w7", lw[7], 32'h0000_0000);
        chk("a_last6", 32'(ll[6]), 0);
        chk("a_last7", 32'(ll[7]), 1);
        tick();

        // Latency 1 and eight back-to-back accepts.
        clear_log();
        chk("b_pre_valid", 32'(dout_valid), 0);
        state_in = pat_b; state_valid = 1;
        tick();
        state_valid = 0;
        chk("b_lat_valid", 32'(dout_valid), 1);
        chk("b_w0", dout, 32'haaaa_aaaa);
        repeat (8) tick();
        chk("b_consec", lw.size(), 8);
        chk("b_last", 32'(ll[7]), 1);
        tick();

        // Back-pressure at word 2.
        clear_log();
        state_in = pat_c; state_valid = 1;
        tick();
        state_valid = 0;
        repeat (2) tick();
        dout_ready = 0;
        held_d = dout; held_l = dout_last;
        chk("c_w2", held_d, expand(pat_c)[2]);
        repeat (3) begin
            tick();
            chk("c_hold_dout", dout, held_d);
            chk("c_hold_last", 32'(dout_last), 32'(held_l));
        end
        dout_ready = 1;
        tick();
        chk("c_w3_after", dout, expand(pat_c)[3]);
        wait_log(8);
        tick();

        // Mid-stream reset after word 5.
        clear_log();
        state_in = pat_c; state_valid = 1;
        tick();
        state_valid = 0;
        wait_log(6);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 0);
        chk("mid_rst_dout", dout, 0);
        tick();
        rst = 0;
        #1;
        chk("mid_rst_ready", 32'(state_ready), 1);
        clear_log();
        state_in = pat_d; state_valid = 1;
        tick();
        state_valid = 0;
        wait_log(8);
        chk("d_w0", lw[0], 32'h0000_0000);
        chk("d_w4", lw[4], 32'hffff_ffff);
        tick();

        // Held state_valid: second state only after last accept plus one bubble.
        clear_log();
        state_in = pat_a; state_valid = 1;
        tick();
        state_in = pat_d;
        repeat (8) tick();
        chk("bubble_ready", 32'(state_ready), 1);
        chk("bubble_valid", 32'(dout_valid), 0);
        wait_log(16);
        state_valid = 0;
        chk("hold_w0", lw[0], 32'hffff_ffff);
        chk("hold_w7", lw[7], 32'h0000_0000);
        chk("hold_w8", lw[8], 32'h0000_0000);
        chk("hold_w12", lw[12], 32'hffff_ffff);
        repeat (2) tick();

        // Buffer contents after a completed transfer.
        e = expand(pat_d);
        for (int k = 0; k < 8; k++) begin
`ifdef MSKSER_ZEROIZE_EN
            chk("buf_zero", dut.words[k], 32'h0);
`else
            chk("buf_retain", dut.words[k], e[k]);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
